phase_manager: RTL and testbench

//  Phase-shedding controller for the 4-phase buck. Once per PWM period it compares the

---
 rtl/phase_manager_if.sv | 31 +++
 rtl/phase_manager.sv | 154 +++++++++++++++
 tb/tb_phase_manager.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_manager_if.sv
// phase_manager_if
//   Groups the phase-manager control inputs, the phase-shifted PWM inputs and the
//   gated drive / status outputs into one bundle. clk and rst are not part of it.
//   master : drives period_start, enable, fault, d_cmd, high_in, low_in;
//            observes high_out, low_out, n_active, state
//   slave  : the phase_manager side (the mirror image of master)
interface phase_manager_if #(
    parameter int NPHASES = 4,
    parameter int DW      = 10
);
    logic               period_start;
    logic               enable;
    logic               fault;
    logic [DW-1:0]      d_cmd;
    logic [NPHASES-1:0] high_in;
    logic [NPHASES-1:0] low_in;
    logic [NPHASES-1:0] high_out;
    logic [NPHASES-1:0] low_out;
    logic [2:0]         n_active;
    logic [1:0]         state;

    modport master (
        output period_start, enable, fault, d_cmd, high_in, low_in,
        input  high_out, low_out, n_active, state
    );

    modport slave (
        input  period_start, enable, fault, d_cmd, high_in, low_in,
        output high_out, low_out, n_active, state
    );
endinterface

// File: rtl/phase_manager.sv
// phase_manager
//   Phase-shedding controller for a multi-phase buck. Once per PWM period the duty
//   command is compared against add/shed thresholds; a qualifying condition held for
//   HOLD consecutive periods adds or sheds one phase. Disabled phases hold both FETs
//   off. Also sequences start-up, ordered shut-down and fault blanking.
//   Ports:
//     clk   in  system clock (same clock as the DPWM counter)
//     rst   in  asynchronous active-low reset
//     bus   slave side of phase_manager_if:
//             period_start, enable, fault, d_cmd, high_in, low_in  (inputs)
//             high_out, low_out, n_active, state                   (outputs)
module phase_manager #(
    parameter int            NPHASES = 4,
    parameter int            DW      = 10,
    parameter logic [DW-1:0] ADD_TH  = DW'(400),
    parameter logic [DW-1:0] SHED_TH = DW'(250),
    parameter int            HOLD    = 8
) (
    input  logic            clk,
    input  logic            rst,
    phase_manager_if.slave  bus
);
    localparam int            CW      = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLD);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
    localparam logic [2:0]    NPH_C   = 3'(NPHASES);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_SHUT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t             state_q;
    logic [2:0]         n_q;
    logic [CW-1:0]      up_q;
    logic [CW-1:0]      dn_q;
    logic [NPHASES-1:0] target_mask;
    logic [NPHASES-1:0] mask_d;
    logic [NPHASES-1:0] mask_q;
    logic [NPHASES-1:0] high_out_q;
    logic [NPHASES-1:0] low_out_q;

    // Phase-count FSM. Fault is checked every cycle and wins over everything else;
    // all other events are only taken on period_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_OFF;
            n_q     <= '0;
            up_q    <= '0;
            dn_q    <= '0;
        end else if (bus.fault) begin
            state_q <= S_FAULT;
            n_q     <= '0;
            up_q    <= '0;
            dn_q    <= '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (bus.period_start && bus.enable) begin
                        state_q <= S_RUN;
                        n_q     <= 3'd1;
                    end
                end
                S_RUN: begin
                    if (bus.period_start) begin
                        if (!bus.enable) begin
                            state_q <= S_SHUT;
                            up_q    <= '0;
                            dn_q    <= '0;
                        end else if (bus.d_cmd > ADD_TH) begin
                            dn_q <= '0;
                            // This period is the HOLD-th qualifying one.
                            if (up_q >= HOLD_M1) begin
                                if (n_q < NPH_C) begin
                                    n_q  <= n_q + 3'd1;
                                    up_q <= '0;
                                end else begin
                                    up_q <= HOLD_C;
                                end
                            end else begin
                                up_q <= up_q + CW'(1);
                            end
                        end else if (bus.d_cmd < SHED_TH) begin
                            up_q <= '0;
                            if (dn_q >= HOLD_M1) begin
                                if (n_q > 3'd1) begin
                                    n_q  <= n_q - 3'd1;
                                    dn_q <= '0;
                                end else begin
                                    dn_q <= HOLD_C;
                                end
                            end else begin
                                dn_q <= dn_q + CW'(1);
                            end
                        end else begin
                            up_q <= '0;
                            dn_q <= '0;
                        end
                    end
                end
                S_SHUT: begin
                    if (bus.period_start) begin
                        if (bus.enable) begin
                            state_q <= S_RUN;
                            if (n_q == 3'd0) n_q <= 3'd1;
                        end else if (n_q <= 3'd1) begin
                            n_q     <= '0;
                            state_q <= S_OFF;
                        end else begin
                            n_q <= n_q - 3'd1;
                        end
                    end
                end
                S_FAULT: begin
                    // fault is already known to be low on this branch
                    if (!bus.enable) state_q <= S_OFF;
                end
                default: state_q <= S_OFF;
            endcase
        end
    end

    // Phase 0 is added first and shed last. A mask bit only changes while its
    // high-side input is low, so an enabled/disabled phase never emits a runt pulse.
    always_comb begin
        target_mask = '0;
        mask_d      = mask_q;
        for (int i = 0; i < NPHASES; i++) begin
            target_mask[i] = (3'(i) < n_q);
            if (!bus.high_in[i]) mask_d[i] = target_mask[i];
        end
        if (bus.fault) mask_d = '0;
    end

    // Drive outputs are registered; fault blanks them on the edge that samples it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q     <= '0;
            high_out_q <= '0;
            low_out_q  <= '0;
        end else begin
            mask_q     <= mask_d;
            high_out_q <= bus.fault ? '0 : (mask_q & bus.high_in);
            low_out_q  <= bus.fault ? '0 : (mask_q & bus.low_in);
        end
    end

    assign bus.high_out = high_out_q;
    assign bus.low_out  = low_out_q;
    assign bus.n_active = n_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_phase_manager.sv
// tb_phase_manager
//   Directed bench for phase_manager. Stimulus pushes expected values (tagged with
//   the monitor sample on which they must hold) into a scoreboard queue; a separate
//   monitor samples the DUT on every falling edge and pops/compares due entries.
module tb_phase_manager;
    logic clk = 1'b0;
    logic rst = 1'b0;

    phase_manager_if #(.NPHASES(4), .DW(10)) bus();

    phase_manager dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         sel;   // 0 n_active, 1 state, 2 high_out, 3 low_out
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    int   cyc      = 0;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    // Monitor: one sample per falling edge, well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                exp_t       e;
                logic [7:0] act;
                e = sbq.pop_front();
                case (e.sel)
                    0:       act = 8'(bus.n_active);
                    1:       act = 8'(bus.state);
                    2:       act = 8'(bus.high_out);
                    default: act = 8'(bus.low_out);
                endcase
                tot_cnt = tot_cnt + 1;
                if (e.cyc < cyc) begin
                    $display("FAIL %s: check missed its sample (due %0d, now %0d)", e.nm, e.cyc, cyc);
                end else if (act !== e.val) begin
                    $display("FAIL %s: got %0h expected %0h", e.nm, act, e.val);
                end else begin
                    pass_cnt = pass_cnt + 1;
                end
            end
        end
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Expected value for the next monitor sample (called at rising edge + 1).
    task automatic expect_v(input int sel, input logic [7:0] val, input string nm);
        exp_t e;
        e.cyc = cyc + 1;
        e.sel = sel;
        e.val = val;
        e.nm  = nm;
        sbq.push_back(e);
    endtask

    // One PWM period: a period_start cycle followed by one idle cycle.
    task automatic run_period(input logic [9:0] d, input logic [2:0] en,
                              input logic [1:0] es, input string nm);
        bus.d_cmd        = d;
        bus.period_start = 1'b1;
        clk_step();
        bus.period_start = 1'b0;
        expect_v(0, 8'(en), {nm, "_n"});
        expect_v(1, 8'(es), {nm, "_st"});
        clk_step();
    endtask

    logic [3:0] t5_hi [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [3:0] t5_lo [5] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0111};

    initial begin
        bus.period_start = 1'b0;
        bus.enable       = 1'b0;
        bus.fault        = 1'b0;
        bus.d_cmd        = '0;
        bus.high_in      = '0;
        bus.low_in       = '0;

        // reset state
        clk_step();
        expect_v(0, 8'd0, "rst_n");
        expect_v(1, 8'd0, "rst_st");
        expect_v(2, 8'd0, "rst_hi");
        expect_v(3, 8'd0, "rst_lo");
        clk_step();
        rst = 1'b1;
        clk_step();

        // T2: ramp up 1->2->3->4 at periods 1, 9, 17, 25, then hold at 4
        bus.enable = 1'b1;
        for (int p = 1; p <= 40; p++) begin
            int n_e;
            n_e = 1 + (p - 1) / 8;
            if (n_e > 4) n_e = 4;
            run_period(10'd500, 3'(n_e), 2'd1, $sformatf("t2_p%0d", p));
        end

        // T3: shed one phase every 8 periods down to 1, then stay at 1
        for (int q = 1; q <= 32; q++) begin
            int n_e;
            n_e = 4 - q / 8;
            if (n_e < 1) n_e = 1;
            run_period(10'd100, 3'(n_e), 2'd1, $sformatf("t3_q%0d", q));
        end
        for (int q = 1; q <= 4; q++) run_period(10'd300, 3'd1, 2'd1, "t3_band");

        // T4: 7 periods high then 1 in band never reaches the add count
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 7; k++) run_period(10'd500, 3'd1, 2'd1, "t4_hi");
            run_period(10'd300, 3'd1, 2'd1, "t4_band");
        end

        // A band period also clears the shed count
        for (int k = 1; k <= 8; k++)
            run_period(10'd500, (k == 8) ? 3'd2 : 3'd1, 2'd1, "dn_up");
        for (int k = 0; k < 7; k++) run_period(10'd100, 3'd2, 2'd1, "dn_a");
        run_period(10'd300, 3'd2, 2'd1, "dn_band");
        for (int k = 0; k < 7; k++) run_period(10'd100, 3'd2, 2'd1, "dn_b");
        run_period(10'd100, 3'd1, 2'd1, "dn_shed");

        // Climb to 3 phases for the asynchronous reset check
        for (int k = 1; k <= 16; k++)
            run_period(10'd500, 3'(1 + k / 8), 2'd1, $sformatf("up3_k%0d", k));

        // T1: rst low mid-RUN with n_active=3 clears everything without a clock edge
        bus.high_in = 4'b1111;
        clk_step();
        expect_v(2, 8'h07, "t1_pre_hi");
        expect_v(0, 8'd3,  "t1_pre_n");
        clk_step();
        rst = 1'b0;
        expect_v(0, 8'd0, "t1_n");
        expect_v(1, 8'd0, "t1_st");
        expect_v(2, 8'd0, "t1_hi");
        expect_v(3, 8'd0, "t1_lo");
        clk_step();
        bus.high_in = '0;
        bus.enable  = 1'b0;
        rst         = 1'b1;
        clk_step();

        // Ordered shut-down, re-enable mid shut-down, then shut-down to OFF
        bus.enable = 1'b1;
        run_period(10'd300, 3'd1, 2'd1, "sd_start");
        for (int k = 1; k <= 8; k++)
            run_period(10'd500, (k == 8) ? 3'd2 : 3'd1, 2'd1, "sd_up");
        bus.enable = 1'b0;
        run_period(10'd300, 3'd2, 2'd2, "sd_enter");
        run_period(10'd300, 3'd1, 2'd2, "sd_dec");
        bus.enable = 1'b1;
        run_period(10'd300, 3'd1, 2'd1, "sd_resume");
        bus.enable = 1'b0;
        run_period(10'd300, 3'd1, 2'd2, "sd_enter2");
        run_period(10'd300, 3'd0, 2'd0, "sd_off");

        // T5: phase 2 enabled while its high input is high
        bus.enable = 1'b1;
        run_period(10'd500, 3'd1, 2'd1, "t5_start");
        for (int k = 1; k <= 8; k++)
            run_period(10'd500, (k == 8) ? 3'd2 : 3'd1, 2'd1, "t5_up2");
        bus.high_in = 4'b0100;
        bus.low_in  = 4'b1011;
        for (int k = 1; k <= 8; k++)
            run_period(10'd500, (k == 8) ? 3'd3 : 3'd2, 2'd1, "t5_up3");
        clk_step();
        expect_v(2, 8'h00, "t5_gated_hi");
        expect_v(3, 8'h03, "t5_gated_lo");
        for (int k = 0; k < 5; k++) begin
            bus.high_in = (k >= 1 && k <= 3) ? 4'b0100 : 4'b0000;
            bus.low_in  = ~bus.high_in;
            clk_step();
            expect_v(2, 8'(t5_hi[k]), $sformatf("t5_hi_%0d", k));
            expect_v(3, 8'(t5_lo[k]), $sformatf("t5_lo_%0d", k));
        end

        // T6: fault mid-pulse blanks drives on the next edge; exit needs enable low
        bus.high_in = 4'b0111;
        bus.low_in  = 4'b0000;
        clk_step();
        expect_v(2, 8'h07, "t6_pre_hi");
        bus.fault  = 1'b1;
        bus.low_in = 4'b1000;
        clk_step();
        expect_v(2, 8'h00, "t6_hi");
        expect_v(3, 8'h00, "t6_lo");
        expect_v(1, 8'd3,  "t6_st");
        expect_v(0, 8'd0,  "t6_n");
        clk_step();
        expect_v(2, 8'h00, "t6_hold_hi");
        bus.fault = 1'b0;
        clk_step();
        expect_v(1, 8'd3,  "t6_en_st");
        expect_v(2, 8'h00, "t6_en_hi");
        run_period(10'd500, 3'd0, 2'd3, "t6_ps");
        bus.enable = 1'b0;
        clk_step();
        expect_v(1, 8'd0, "t6_off_st");
        expect_v(0, 8'd0, "t6_off_n");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sbq.size() != 0; i++) clk_step();
        if (sbq.size() != 0) begin
            tot_cnt = tot_cnt + 1;
            $display("FAIL drain: %0d checks left unsampled, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
